// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the I/D-cache to physical-memory arbiter: FSM states,
// grant owner and the round-robin pick used when both caches miss together.
package cache_mem_arbiter_pkg;

  localparam int LINE_W_DEF = 256;
  localparam int ADDR_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } arb_grant_t;

  // Contention goes to whichever side did not win last time.
  function automatic arb_grant_t rr_pick(input logic i_req, input logic d_req,
                                         input arb_grant_t last);
    arb_grant_t pick;
    if (i_req && d_req) begin
      pick = (last == GRANT_I) ? GRANT_D : GRANT_I;
    end else if (d_req) begin
      pick = GRANT_D;
    end else begin
      pick = GRANT_I;
    end
    return pick;
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of both cache miss ports and the cacheline adaptor port.
// The arbiter takes the slave view; its environment takes the master view.
interface cache_mem_arbiter_if
  import cache_mem_arbiter_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one cacheline memory port between the I-cache
// and D-cache; one transaction at a time, with a DONE bubble after each.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
)(
  input logic                clk,
  input logic                rst_n,
  cache_mem_arbiter_if.slave bus
);

  arb_state_t state_r;
  arb_state_t state_s;
  arb_grant_t last_grant_r;
  arb_grant_t last_grant_s;
  arb_grant_t pick_s;
  logic       d_req_s;

  assign d_req_s = bus.d_read | bus.d_write;
  assign pick_s  = rr_pick(bus.i_read, d_req_s, last_grant_r);

  // State and last-grant registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= GRANT_I;
    end else begin
      state_r      <= state_s;
      last_grant_r <= last_grant_s;
    end
  end

  // Next-state: grant from IDLE, hold until mem_resp, one bubble in DONE.
  always_comb begin
    state_s      = state_r;
    last_grant_s = last_grant_r;
    case (state_r)
      IDLE: begin
        if (bus.i_read || d_req_s) begin
          last_grant_s = pick_s;
          state_s      = (pick_s == GRANT_D) ? SERVE_D : SERVE_I;
        end else begin
          state_s = IDLE;
        end
      end
      SERVE_I, SERVE_D: state_s = bus.mem_resp ? DONE : state_r;
      DONE:             state_s = IDLE;
      default:          state_s = IDLE;
    endcase
  end

  // Output muxes; the side not being served always sees zero data and no resp.
  always_comb begin
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = {ADDR_W{1'b0}};
    bus.mem_wdata = {LINE_W{1'b0}};
    bus.i_rdata   = {LINE_W{1'b0}};
    bus.i_resp    = 1'b0;
    bus.d_rdata   = {LINE_W{1'b0}};
    bus.d_resp    = 1'b0;
    case (state_r)
      SERVE_I: begin
        bus.mem_read = 1'b1;
        bus.mem_addr = bus.i_addr;
        bus.i_rdata  = bus.mem_rdata;
        bus.i_resp   = bus.mem_resp;
      end
      SERVE_D: begin
        // A simultaneous read and write from the D-cache resolves to the write.
        bus.mem_read  = bus.d_read & ~bus.d_write;
        bus.mem_write = bus.d_write;
        bus.mem_addr  = bus.d_addr;
        bus.mem_wdata = bus.d_wdata;
        bus.d_rdata   = bus.mem_rdata;
        bus.d_resp    = bus.mem_resp;
      end
      default: begin
        bus.mem_read = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed and randomized checks of cache_mem_arbiter against a transaction
// level reference (who owns the memory port, plus a one-cycle bubble).
module tb_cache_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_mem_arbiter_if bus ();

  cache_mem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference: owner 0 = nobody, 1 = I-cache, 2 = D-cache.
  int owner = 0;
  bit bubble = 1'b0;
  bit last_was_d = 1'b0;
  bit new_grant = 1'b0;

  bit obs_i_resp, obs_d_resp;
  int n_i_resp = 0;
  int n_d_resp = 0;
  int illegal_cnt = 0;
  int served_q[$];

  bit i_pend = 1'b0;
  bit d_pend = 1'b0;
  int i_left = 0;
  int d_left = 0;
  int i_foreign = 0;
  int d_foreign = 0;
  int mem_wait = 0;
  logic [255:0] line_pat = 256'd0;

  // Counts cycles where the D-cache drives the illegal read+write combination.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.d_read === 1'b1 && bus.d_write === 1'b1)
      illegal_cnt <= illegal_cnt + 1;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic int q_at(input int idx);
    if (idx < served_q.size()) return served_q[idx];
    return -1;
  endfunction

  task automatic check_outputs(input string tag);
    logic         e_rd, e_wr, e_ir, e_dr;
    logic [31:0]  e_addr;
    logic [255:0] e_wd, e_id, e_dd;
    e_rd = 1'b0; e_wr = 1'b0; e_ir = 1'b0; e_dr = 1'b0;
    e_addr = 32'd0; e_wd = 256'd0; e_id = 256'd0; e_dd = 256'd0;
    if (owner == 1) begin
      e_rd = 1'b1; e_addr = bus.i_addr; e_id = bus.mem_rdata; e_ir = bus.mem_resp;
    end else if (owner == 2) begin
      e_wr = bus.d_write; e_rd = bus.d_read & ~bus.d_write;
      e_addr = bus.d_addr; e_wd = bus.d_wdata; e_dd = bus.mem_rdata; e_dr = bus.mem_resp;
    end
    chk({tag, ".mem_read"},  bus.mem_read,  e_rd);
    chk({tag, ".mem_write"}, bus.mem_write, e_wr);
    chk({tag, ".mem_addr"},  bus.mem_addr,  e_addr);
    chk({tag, ".mem_wdata"}, bus.mem_wdata, e_wd);
    chk({tag, ".i_rdata"},   bus.i_rdata,   e_id);
    chk({tag, ".i_resp"},    bus.i_resp,    e_ir);
    chk({tag, ".d_rdata"},   bus.d_rdata,   e_dd);
    chk({tag, ".d_resp"},    bus.d_resp,    e_dr);
  endtask

  // Reference update at a clock edge, from the inputs held across that edge.
  task automatic model_update();
    bit want_i, want_d;
    new_grant = 1'b0;
    want_i = (bus.i_read === 1'b1);
    want_d = (bus.d_read === 1'b1) || (bus.d_write === 1'b1);
    if (rst_n !== 1'b1) begin
      owner = 0; bubble = 1'b0; last_was_d = 1'b0;
    end else if (owner != 0) begin
      if (bus.mem_resp === 1'b1) begin owner = 0; bubble = 1'b1; end
    end else if (bubble) begin
      bubble = 1'b0;
    end else if (want_i || want_d) begin
      if (want_i && want_d) owner = last_was_d ? 1 : 2;
      else owner = want_i ? 1 : 2;
      last_was_d = (owner == 2);
      new_grant = 1'b1;
    end
  endtask

  task automatic step(input string tag);
    @(negedge clk);
    check_outputs(tag);
    obs_i_resp = (bus.i_resp === 1'b1);
    obs_d_resp = (bus.d_resp === 1'b1);
    if (obs_i_resp) begin n_i_resp++; served_q.push_back(1); end
    if (obs_d_resp) begin n_d_resp++; served_q.push_back(2); end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic raise_i(input logic [31:0] a);
    i_pend = 1'b1; bus.i_read = 1'b1; bus.i_addr = a;
  endtask

  task automatic raise_d(input bit wr, input logic [31:0] a, input logic [255:0] wd);
    d_pend = 1'b1; bus.d_read = ~wr; bus.d_write = wr; bus.d_addr = a; bus.d_wdata = wd;
  endtask

  // Memory model plus requesters that hold until resp and drop in the bubble.
  task automatic run_traffic(input string tag, input int target, input int max_cyc,
                             input int p_raise, input int lat_lo, input int lat_hi,
                             input bit chaos);
    int got = 0;
    int cyc = 0;
    bit drop_i, drop_d;
    while (got < target && cyc < max_cyc) begin
      if (new_grant) mem_wait = $urandom_range(lat_hi, lat_lo);
      bus.mem_resp = 1'b0;
      if (owner != 0) begin
        if (mem_wait == 0) begin
          bus.mem_resp = 1'b1;
          bus.mem_rdata = chaos ? rand_line() : line_pat;
        end else begin
          mem_wait--;
        end
      end else if (chaos && $urandom_range(7, 0) == 0) begin
        bus.mem_resp = 1'b1;
      end
      rst_n = !(chaos && $urandom_range(63, 0) == 0);
      step(tag);
      cyc++;
      drop_i = obs_i_resp;
      drop_d = obs_d_resp;
      if (obs_d_resp && i_pend) i_foreign++;
      if (obs_i_resp && d_pend) d_foreign++;
      if (obs_i_resp) begin
        chk({tag, ".i_wait_le1"}, (i_foreign <= 1), 1'b1);
        i_foreign = 0; i_pend = 1'b0; bus.i_read = 1'b0; got++;
      end
      if (obs_d_resp) begin
        chk({tag, ".d_wait_le1"}, (d_foreign <= 1), 1'b1);
        d_foreign = 0; d_pend = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0; got++;
      end
      if (rst_n !== 1'b1) begin i_foreign = 0; d_foreign = 0; end
      rst_n = 1'b1;
      if (!i_pend && !drop_i && i_left > 0 && $urandom_range(99, 0) < p_raise) begin
        raise_i($urandom() & 32'hFFFF_FFE0); i_left--;
      end
      if (!d_pend && !drop_d && d_left > 0 && $urandom_range(99, 0) < p_raise) begin
        raise_d($urandom_range(1, 0) == 1, $urandom() & 32'hFFFF_FFE0, rand_line()); d_left--;
      end
    end
    bus.mem_resp = 1'b0;
    chk({tag, ".resp_count"}, got, target);
  endtask

  initial begin
    int base_i, base_d, base_q, base_ill;
    rst_n = 1'b0;
    bus.i_read = 1'b1; bus.i_addr = 32'h0000_0060;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = 32'd0; bus.d_wdata = 256'd0;
    bus.mem_rdata = 256'd0; bus.mem_resp = 1'b0;
    i_pend = 1'b1;
    @(posedge clk);
    model_update();
    #1;

    // Reset held two cycles with a pending I read, then the grant to I.
    step("rst0");
    step("rst1");
    rst_n = 1'b1;
    line_pat = rand_line();
    run_traffic("t1_reset", 1, 40, 0, 2, 2, 1'b0);
    step("t1_done");
    step("t1_idle");

    // Lone I read, memory answers after four cycles with an A-pattern line.
    base_i = n_i_resp; base_d = n_d_resp;
    line_pat = {8{32'hAAAA_AAAA}};
    raise_i(32'h0000_0100);
    run_traffic("t2_lone_i", 1, 40, 0, 4, 4, 1'b0);
    step("t2_done");
    step("t2_idle");
    chk("t2_i_resp_pulses", n_i_resp - base_i, 1);
    chk("t2_d_resp_pulses", n_d_resp - base_d, 0);

    // Simultaneous I read and D write straight out of reset: D first.
    rst_n = 1'b0;
    step("t3_rst");
    rst_n = 1'b1;
    base_q = served_q.size();
    line_pat = rand_line();
    raise_i(32'h0000_0200);
    raise_d(1'b1, 32'h8000_0040, {8{32'h5555_5555}});
    run_traffic("t3_both", 2, 60, 0, 1, 3, 1'b0);
    chk("t3_first_is_d", q_at(base_q), 2);
    chk("t3_second_is_i", q_at(base_q + 1), 1);
    step("t3_done");
    step("t3_idle");

    // Back-to-back contention, three transactions per side, strict alternation.
    base_q = served_q.size();
    raise_i($urandom() & 32'hFFFF_FFE0);
    raise_d(1'b0, $urandom() & 32'hFFFF_FFE0, rand_line());
    i_left = 2; d_left = 2;
    run_traffic("t4_contend", 6, 120, 100, 0, 3, 1'b0);
    for (int k = 0; k < 6; k++)
      chk($sformatf("t4_grant_%0d", k), q_at(base_q + k), (k % 2 == 0) ? 2 : 1);
    step("t4_done");
    step("t4_idle");

    // Reset two cycles before the write's response; the late resp is ignored.
    base_d = n_d_resp;
    raise_d(1'b1, 32'h8000_0080, rand_line());
    step("t5_grant");
    step("t5_serve");
    rst_n = 1'b0;
    step("t5_rst");
    rst_n = 1'b1;
    bus.d_write = 1'b0; d_pend = 1'b0;
    step("t5_idle");
    bus.mem_resp = 1'b1; bus.mem_rdata = rand_line();
    step("t5_late_resp");
    bus.mem_resp = 1'b0;
    step("t5_after");
    chk("t5_no_d_resp", n_d_resp - base_d, 0);

    // Illegal D read+write: served as a write; the monitor must notice it.
    base_ill = illegal_cnt;
    raise_d(1'b1, 32'h0000_0ABC & 32'hFFFF_FFE0, rand_line());
    bus.d_read = 1'b1;
    step("t6_grant");
    step("t6_serve");
    bus.mem_resp = 1'b1; bus.mem_rdata = rand_line();
    step("t6_resp");
    bus.mem_resp = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0; d_pend = 1'b0;
    step("t6_done");
    chk("t6_illegal_seen", illegal_cnt - base_ill, 3);
    step("t6_idle");

    // Random traffic with random latency, stray responses and random resets.
    i_left = 1000; d_left = 1000;
    run_traffic("t7_random", 80, 4000, 30, 0, 5, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single physical-memory line port between the I-cache and D-cache of the 5-stage RV32I pipeline.
- Sits between both cache miss paths and the cacheline adaptor.
- Grants one requester at a time under round-robin priority.
- Forwards the line transaction and returns a one-cycle response pulse to the granted cache.
- Never services two requests concurrently.

Parameters:
- LINE_W, 256, cacheline width in bits.
- ADDR_W, 32, address width in bits.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- i_read  in  1  I-cache line read request; level, held until i_resp.
- i_addr  in  ADDR_W  I-cache line address.
- i_rdata  out  LINE_W  line returned to I-cache.
- i_resp  out  1  I-cache completion pulse.
- d_read  in  1  D-cache line read request; level.
- d_write  in  1  D-cache writeback request; level.
- d_addr  in  ADDR_W  D-cache line address.
- d_wdata  in  LINE_W  D-cache writeback line.
- d_rdata  out  LINE_W  line returned to D-cache.
- d_resp  out  1  D-cache completion pulse.
- mem_read  out  1  read to adaptor.
- mem_write  out  1  write to adaptor.
- mem_addr  out  ADDR_W  address to adaptor.
- mem_wdata  out  LINE_W  write line to adaptor.
- mem_rdata  in  LINE_W  line from adaptor.
- mem_resp  in  1  adaptor completion; one-cycle pulse.

Behaviour:
- Reset: rst_n low at a rising edge forces state=IDLE and last_grant=I; this applies mid-transaction too, and the in-flight transaction is abandoned.
- Outputs are combinational from state; in IDLE/DONE all mem_* controls and i_resp/d_resp are 0.
- States: IDLE, SERVE_I, SERVE_D, DONE.
- IDLE transitions:
  - only i_read -> SERVE_I.
  - only d_read|d_write -> SERVE_D.
  - both pending -> serve the side not equal to last_grant; after reset D wins first.
  - neither -> stay in IDLE.
  - last_grant updates on entry to SERVE_x.
  - Grant decision takes 1 cycle: mem_* asserts the cycle after the request is first seen in IDLE.
- SERVE_I:
  - mem_read=1, mem_write=0, mem_addr=i_addr, mem_wdata=0.
  - i_rdata=mem_rdata.
  - i_resp=mem_resp.
  - on mem_resp -> DONE.
- SERVE_D:
  - mem_read=d_read, mem_write=d_write, mem_addr=d_addr, mem_wdata=d_wdata.
  - d_rdata=mem_rdata.
  - d_resp=mem_resp.
  - on mem_resp -> DONE.
- d_read and d_write together is illegal; the bench asserts on it, and the RTL gives write precedence (mem_read=0).
- DONE: a one-cycle bubble, then -> IDLE. This lets the served cache drop its request so a stale level is never re-granted.
- Ungranted side: its resp stays 0 and its rdata is 0; requests are held, never dropped.
- Requester deasserting before its resp while in SERVE_x is illegal; the arbiter keeps serving until mem_resp.
- mem_resp outside SERVE_x is ignored.
- Minimum turnaround per transaction: 1 (grant) + N (memory) + 1 (DONE) cycles.
- Starvation bound: a pending requester waits at most one foreign transaction.

Decomposition:
- Add arb_state_t (IDLE, SERVE_I, SERVE_D, DONE) and arb_grant_t (GRANT_I, GRANT_D) enums to rv32i_types.
- No sub-module; the FSM and output muxes stay in cache_mem_arbiter.

Test Plan:
- Reset: hold rst_n=0 two cycles with i_read=1 -> all mem_* and resp 0; one cycle after rst_n=1, mem_read=1 with mem_addr=i_addr=0x0000_0060.
- Lone I read: i_addr=0x0000_0100; memory responds after 4 cycles with rdata=0xAAAA…A -> i_resp high exactly 1 cycle carrying that data; d_resp stays 0; DONE visible.
- Simultaneous I read 0x200 and D write 0x8000_0040 (wdata=0x5555…5) from reset -> D served first (mem_write=1), then I (mem_read=1); last_grant alternates.
- Back-to-back contention: both sides re-request immediately for 3 transactions each -> grant sequence D,I,D,I,D,I; no side waits more than one foreign transaction.
- Reset mid-SERVE_D: assert rst_n=0 two cycles before mem_resp -> next cycle state=IDLE, mem_write=0, no d_resp; a late mem_resp is ignored.
- Illegal d_read&d_write=1 -> mem_write=1, mem_read=0, bench assertion fires.
